// File: rtl/dsm_pkg.sv
// Shared constants and types for the delta-sigma decimator and its modulator bench.
package dsm_pkg;

    localparam int unsigned DSM_INT_W  = 4;
    localparam int unsigned DSM_FRAC_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StAccum
    } dsm_state_e;

endpackage

// File: rtl/dsm_decimator_if.sv
// Measurement request, sample stream and result bus of the decimator.
interface dsm_decimator_if;
    import dsm_pkg::*;

    logic                  start;
    logic                  cont;
    logic [DSM_INT_W-1:0]  din;
    logic                  busy;
    logic                  valid;
    logic [DSM_INT_W-1:0]  avg_i;
    logic [DSM_FRAC_W-1:0] avg_f;
    logic [DSM_INT_W-1:0]  min_s;
    logic [DSM_INT_W-1:0]  max_s;

    modport master (
        output start, cont, din,
        input  busy, valid, avg_i, avg_f, min_s, max_s
    );

    modport slave (
        input  start, cont, din,
        output busy, valid, avg_i, avg_f, min_s, max_s
    );

endinterface

// File: rtl/dsm_minmax_tracker.sv
// Running min/max of the sample stream; clear reloads 15/0, load captures results.
module dsm_minmax_tracker
    import dsm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 sample_i,
    input  logic                 load_i,
    input  logic [DSM_INT_W-1:0] din_i,
    output logic [DSM_INT_W-1:0] min_o,
    output logic [DSM_INT_W-1:0] max_o
);

    logic [DSM_INT_W-1:0] run_min_q, run_min_d;
    logic [DSM_INT_W-1:0] run_max_q, run_max_d;
    logic [DSM_INT_W-1:0] min_q, min_d;
    logic [DSM_INT_W-1:0] max_q, max_d;
    logic [DSM_INT_W-1:0] cur_min, cur_max;

    // Extremes including this cycle's sample, so a load sees the window's last din.
    always_comb begin
        cur_min = run_min_q;
        cur_max = run_max_q;
        if (sample_i) begin
            if (din_i < run_min_q) cur_min = din_i;
            if (din_i > run_max_q) cur_max = din_i;
        end
        run_min_d = clear_i ? '1 : cur_min;
        run_max_d = clear_i ? '0 : cur_max;
        min_d     = load_i ? cur_min : min_q;
        max_d     = load_i ? cur_max : max_q;
    end

    // Running and captured extremes; captured outputs reset to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_min_q <= '1;
            run_max_q <= '0;
            min_q     <= '0;
            max_q     <= '0;
        end else begin
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            min_q     <= min_d;
            max_q     <= max_d;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;

endmodule

// File: rtl/dsm_decimator.sv
// Windowed accumulate-and-dump decimator for the 4-bit MASH modulator stream.
module dsm_decimator
    import dsm_pkg::*;
#(
    parameter int unsigned LOG2_WIN = 16,
    parameter int unsigned SETTLE   = 10
) (
    input logic            clk,
    input logic            rst,
    dsm_decimator_if.slave bus
);

    localparam int unsigned         AccW       = DSM_INT_W + LOG2_WIN;
    localparam logic [LOG2_WIN-1:0] WinLast    = '1;
    localparam logic [7:0]          SettleLast = 8'(SETTLE - 1);

    dsm_state_e            state_q, state_d;
    logic [7:0]            settle_q, settle_d;
    logic [LOG2_WIN-1:0]   win_q, win_d;
    logic [AccW-1:0]       acc_q, acc_d;
    logic [AccW-1:0]       sum;
    logic                  valid_q;
    logic [DSM_INT_W-1:0]  avg_i_q, avg_i_d;
    logic [DSM_FRAC_W-1:0] avg_f_q, avg_f_d;
    logic                  accum;
    logic                  win_end;

    assign accum   = (state_q == StAccum);
    assign win_end = accum && (win_q == WinLast);
    assign sum     = acc_q + AccW'(bus.din);

    // Next state plus settle/window counters and accumulator.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        win_d    = win_q;
        acc_d    = acc_q;
        unique case (state_q)
            StIdle: begin
                settle_d = '0;
                win_d    = '0;
                acc_d    = '0;
                // valid_q keeps busy high for the result cycle, so start is refused there too.
                if (bus.start && !valid_q) begin
                    state_d = (SETTLE > 0) ? StSettle : StAccum;
                end
            end
            StSettle: begin
                settle_d = settle_q + 8'd1;
                if (settle_q == SettleLast) state_d = StAccum;
            end
            StAccum: begin
                win_d = win_q + 1'b1;
                acc_d = sum;
                if (win_end) begin
                    acc_d = '0;
                    if (!bus.cont) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Result capture at window end: integer bits on top, fraction left-aligned.
    always_comb begin
        avg_i_d = avg_i_q;
        avg_f_d = avg_f_q;
        if (win_end) begin
            avg_i_d = sum[AccW-1:LOG2_WIN];
            avg_f_d = DSM_FRAC_W'(sum[LOG2_WIN-1:0]) << (DSM_FRAC_W - LOG2_WIN);
        end
    end

    // State, counters, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            settle_q <= '0;
            win_q    <= '0;
            acc_q    <= '0;
            valid_q  <= 1'b0;
            avg_i_q  <= '0;
            avg_f_q  <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            win_q    <= win_d;
            acc_q    <= acc_d;
            valid_q  <= win_end;
            avg_i_q  <= avg_i_d;
            avg_f_q  <= avg_f_d;
        end
    end

    dsm_minmax_tracker u_minmax (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (!accum || win_end),
        .sample_i (accum),
        .load_i   (win_end),
        .din_i    (bus.din),
        .min_o    (bus.min_s),
        .max_o    (bus.max_s)
    );

    assign bus.busy  = (state_q != StIdle) || valid_q;
    assign bus.valid = valid_q;
    assign bus.avg_i = avg_i_q;
    assign bus.avg_f = avg_f_q;

endmodule

// File: tb/tb_dsm_decimator.sv
// Scoreboard bench for dsm_decimator: three instances with different window/settle sizes.
module tb_dsm_decimator;

    typedef struct packed {
        logic [3:0]  ai;
        logic [15:0] af;
        logic [3:0]  mn;
        logic [3:0]  mx;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    res_t        exp_a[$], exp_b[$], exp_c[$];
    res_t        obs_a[$], obs_b[$], obs_c[$];
    int unsigned ocyc_a[$], ocyc_b[$], ocyc_c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsm_decimator_if bus_a ();
    dsm_decimator_if bus_b ();
    dsm_decimator_if bus_c ();

    dsm_decimator #(.LOG2_WIN(4), .SETTLE(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    dsm_decimator #(.LOG2_WIN(5), .SETTLE(3)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));
    dsm_decimator                             dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    // Observed results, recorded away from the active edge.
    always @(negedge clk) begin
        if (bus_a.valid === 1'b1) begin
            obs_a.push_back({bus_a.avg_i, bus_a.avg_f, bus_a.min_s, bus_a.max_s});
            ocyc_a.push_back(cyc);
        end
        if (bus_b.valid === 1'b1) begin
            obs_b.push_back({bus_b.avg_i, bus_b.avg_f, bus_b.min_s, bus_b.max_s});
            ocyc_b.push_back(cyc);
        end
        if (bus_c.valid === 1'b1) begin
            obs_c.push_back({bus_c.avg_i, bus_c.avg_f, bus_c.min_s, bus_c.max_s});
            ocyc_c.push_back(cyc);
        end
    end

    function automatic res_t model(input longint sum, input int w, input int mn, input int mx);
        res_t   r;
        longint mask;
        mask = (longint'(1) << w) - 1;
        r.ai = 4'((sum >> w) & 15);
        r.af = 16'((sum & mask) << (16 - w));
        r.mn = 4'(mn);
        r.mx = 4'(mx);
        return r;
    endfunction

    task automatic drive(input int sel, input logic st, input logic [3:0] d);
        case (sel)
            0:       begin bus_a.start = st; bus_a.din = d; end
            1:       begin bus_c.start = st; bus_c.din = d; end
            default: begin bus_b.start = st; bus_b.din = d; end
        endcase
    endtask

    task automatic go(input int sel, output int unsigned e0);
        drive(sel, 1'b1, 4'd0);
        @(posedge clk); #1;
        drive(sel, 1'b0, 4'd0);
        e0 = cyc;
    endtask

    // Discarded samples: extreme values that would corrupt results if accumulated.
    task automatic settle(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            drive(sel, 1'b0, (i % 2 == 0) ? 4'd0 : 4'd15);
            @(posedge clk); #1;
        end
    endtask

    // Drives n window samples and pushes the expected window result.
    task automatic feed(input int sel, input int n, input int pat, input bit poke,
                        input int drop_at, input bit push);
        longint s = 0;
        int     mn = 15, mx = 0, v, w;
        w = (sel == 0) ? 4 : (sel == 1) ? 5 : 16;
        for (int i = 0; i < n; i++) begin
            case (pat)
                0:       v = (i % 2 == 0) ? 3 : 4;
                1:       v = 7;
                2:       v = (i % 2 == 0) ? 6 : 8;
                4:       v = 15;
                default: v = int'($urandom_range(15, 0));
            endcase
            drive(sel, poke && ((i % 4 == 1) || (i == n - 1)), 4'(v));
            if (i == drop_at) bus_a.cont = 1'b0;
            s += longint'(v);
            if (v < mn) mn = v;
            if (v > mx) mx = v;
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, 4'd0);
        if (push) begin
            case (sel)
                0:       exp_a.push_back(model(s, w, mn, mx));
                1:       exp_c.push_back(model(s, w, mn, mx));
                default: exp_b.push_back(model(s, w, mn, mx));
            endcase
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus_a.busy, bus_a.valid, bus_b.busy, bus_b.valid, bus_c.busy, bus_c.valid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {bus_a.busy, bus_a.valid, bus_b.busy, bus_b.valid, bus_c.busy, bus_c.valid});
        end
        total++;
        if ({bus_a.avg_i, bus_a.avg_f, bus_a.min_s, bus_a.max_s} !== 28'h0) begin
            bad++;
            $display("FAIL reset_results_a: got %h want 0",
                     {bus_a.avg_i, bus_a.avg_f, bus_a.min_s, bus_a.max_s});
        end
        total++;
        if ({bus_b.avg_i, bus_b.avg_f, bus_b.min_s, bus_b.max_s} !== 28'h0) begin
            bad++;
            $display("FAIL reset_results_b: got %h want 0",
                     {bus_b.avg_i, bus_b.avg_f, bus_b.min_s, bus_b.max_s});
        end
        total++;
        if ({bus_c.avg_i, bus_c.avg_f, bus_c.min_s, bus_c.max_s} !== 28'h0) begin
            bad++;
            $display("FAIL reset_results_c: got %h want 0",
                     {bus_c.avg_i, bus_c.avg_f, bus_c.min_s, bus_c.max_s});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_alternating();
        int unsigned e0, oc;
        res_t        o, e;
        go(0, e0);
        feed(0, 16, 0, 1'b0, -1, 1'b1);
        @(negedge clk);
        total++;
        if (bus_a.busy !== 1'b1) begin
            bad++;
            $display("FAIL alt_busy_valid_cycle: got %b want 1", bus_a.busy);
        end
        @(posedge clk); @(negedge clk);
        total++;
        if (bus_a.busy !== 1'b0) begin
            bad++;
            $display("FAIL alt_busy_after: got %b want 0", bus_a.busy);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs_a.size() == 0 || exp_a.size() == 0) begin
            bad++;
            $display("FAIL alt_valid: got %0d results want 1", obs_a.size());
        end else begin
            o = obs_a.pop_front(); oc = ocyc_a.pop_front(); e = exp_a.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL alt_result: got %h want %h", o, e);
            end
            total++;
            if (oc !== e0 + 16) begin
                bad++;
                $display("FAIL alt_latency: got %0d want %0d", oc - e0, 16);
            end
        end
        total++;
        if (obs_a.size() != 0) begin
            bad++;
            $display("FAIL alt_extra_valid: got %0d want 0", obs_a.size());
        end
    endtask

    task automatic test_settle();
        int unsigned e0, oc;
        res_t        o, e;
        go(1, e0);
        settle(1, 3);
        feed(1, 32, 3, 1'b0, -1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (obs_c.size() == 0 || exp_c.size() == 0) begin
            bad++;
            $display("FAIL settle_valid: got %0d results want 1", obs_c.size());
        end else begin
            o = obs_c.pop_front(); oc = ocyc_c.pop_front(); e = exp_c.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL settle_result: got %h want %h", o, e);
            end
            total++;
            if (oc !== e0 + 35) begin
                bad++;
                $display("FAIL settle_latency: got %0d want %0d", oc - e0, 35);
            end
        end
    endtask

    task automatic test_continuous();
        int unsigned e0, oc;
        res_t        o, e;
        bus_a.cont = 1'b1;
        go(0, e0);
        feed(0, 16, 1, 1'b0, -1, 1'b1);
        feed(0, 16, 2, 1'b0, -1, 1'b1);
        feed(0, 16, 1, 1'b0, 8, 1'b1);
        @(negedge clk);
        total++;
        if (bus_a.busy !== 1'b1) begin
            bad++;
            $display("FAIL cont_busy_last_valid: got %b want 1", bus_a.busy);
        end
        @(posedge clk); @(negedge clk);
        total++;
        if (bus_a.busy !== 1'b0) begin
            bad++;
            $display("FAIL cont_idle_after_drop: got %b want 0", bus_a.busy);
        end
        repeat (20) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs_a.size() == 0 || exp_a.size() == 0) begin
                bad++;
                $display("FAIL cont_valid_%0d: got none want one", k);
            end else begin
                o = obs_a.pop_front(); oc = ocyc_a.pop_front(); e = exp_a.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL cont_result_%0d: got %h want %h", k, o, e);
                end
                total++;
                if (oc !== e0 + 16 * (k + 1)) begin
                    bad++;
                    $display("FAIL cont_spacing_%0d: got %0d want %0d", k, oc - e0, 16 * (k + 1));
                end
            end
        end
        total++;
        if (obs_a.size() != 0) begin
            bad++;
            $display("FAIL cont_extra_valid: got %0d want 0", obs_a.size());
        end
    endtask

    task automatic test_start_ignored();
        int unsigned e0, oc;
        res_t        o, e;
        go(0, e0);
        feed(0, 16, 3, 1'b1, -1, 1'b1);
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        @(negedge clk);
        total++;
        if (bus_a.busy !== 1'b0) begin
            bad++;
            $display("FAIL start_in_valid_cycle: got busy %b want 0", bus_a.busy);
        end
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (obs_a.size() != 1 || exp_a.size() != 1) begin
            bad++;
            $display("FAIL start_valid_count: got %0d want 1", obs_a.size());
        end else begin
            o = obs_a.pop_front(); oc = ocyc_a.pop_front(); e = exp_a.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL start_result: got %h want %h", o, e);
            end
            total++;
            if (oc !== e0 + 16) begin
                bad++;
                $display("FAIL start_latency: got %0d want %0d", oc - e0, 16);
            end
        end
    endtask

    task automatic test_reset_mid();
        int unsigned e0, oc;
        res_t        o, e;
        go(1, e0);
        settle(1, 3);
        feed(1, 5, 3, 1'b0, -1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus_c.busy, bus_c.valid} !== 2'b00) begin
            bad++;
            $display("FAIL rstmid_flags: got %b want 00", {bus_c.busy, bus_c.valid});
        end
        total++;
        if ({bus_c.avg_i, bus_c.avg_f, bus_c.min_s, bus_c.max_s} !== 28'h0) begin
            bad++;
            $display("FAIL rstmid_results: got %h want 0",
                     {bus_c.avg_i, bus_c.avg_f, bus_c.min_s, bus_c.max_s});
        end
        repeat (45) @(posedge clk);
        #1;
        total++;
        if (obs_c.size() != 0) begin
            bad++;
            $display("FAIL rstmid_no_valid: got %0d want 0", obs_c.size());
        end
        go(1, e0);
        settle(1, 3);
        feed(1, 32, 3, 1'b0, -1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (obs_c.size() != 1 || exp_c.size() != 1) begin
            bad++;
            $display("FAIL rstmid_restart_valid: got %0d want 1", obs_c.size());
        end else begin
            o = obs_c.pop_front(); oc = ocyc_c.pop_front(); e = exp_c.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL rstmid_restart_result: got %h want %h", o, e);
            end
            total++;
            if (oc !== e0 + 35) begin
                bad++;
                $display("FAIL rstmid_restart_latency: got %0d want %0d", oc - e0, 35);
            end
        end
    endtask

    task automatic test_full_scale();
        int unsigned e0, oc;
        res_t        o, e;
        go(2, e0);
        settle(2, 10);
        feed(2, 65536, 4, 1'b0, -1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (obs_b.size() != 1 || exp_b.size() != 1) begin
            bad++;
            $display("FAIL full_valid: got %0d want 1", obs_b.size());
        end else begin
            o = obs_b.pop_front(); oc = ocyc_b.pop_front(); e = exp_b.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL full_result: got %h want %h", o, e);
            end
            total++;
            if (oc !== e0 + 65546) begin
                bad++;
                $display("FAIL full_latency: got %0d want %0d", oc - e0, 65546);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.cont = 1'b0; bus_a.din = 4'd0;
        bus_b.start = 1'b0; bus_b.cont = 1'b0; bus_b.din = 4'd0;
        bus_c.start = 1'b0; bus_c.cont = 1'b0; bus_c.din = 4'd0;
        test_reset();
        test_alternating();
        test_settle();
        test_continuous();
        test_start_ignored();
        test_reset_mid();
        test_full_scale();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
